axis_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-stream output channel between `NUM` AXI-stream requesters. Each source feeds it through its own skid buffer. Once a source is granted, the arbiter holds the grant for that source until the beat carrying `i_last` completes, so packets from different sources never interleave. The output drives a downstream skid buffer or the header-insertion stage.

---
 rtl/axis_rr_arbiter.sv | 114 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges NUM AXI-stream sources onto one
// output, holding each grant until the granted source's last beat completes.
module axis_rr_arbiter #(
    parameter int NUM = 4,
    parameter int DW  = 32,
    parameter int GW  = $clog2(NUM)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM-1:0]    i_valid,
    input  logic [NUM*DW-1:0] i_data,
    input  logic [NUM-1:0]    i_last,
    output logic [NUM-1:0]    o_ready,
    output logic              o_valid,
    output logic [DW-1:0]     o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic [GW-1:0]     o_grant,
    output logic              o_busy
);

    // Handshake rule on every port pair: a beat moves on a rising edge where
    // valid and ready are both high; valid, once raised, holds until that edge.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_prio_last;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   w_prio_nxt;
    logic [GW-1:0]   w_winner;
    logic            w_any;
    logic            w_eop;
    logic [DW-1:0]   w_src_data [NUM];

    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
        assign w_src_data[gi] = i_data[gi*DW +: DW];
    end

    // Scan offsets NUM..1 so the smallest offset past prio_last wins last.
    always_comb begin : winner_scan
        logic [GW:0] sum;
        sum      = '0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM; k >= 1; k--) begin
            sum = {1'b0, r_prio_last} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM)) begin
                sum = sum - (GW+1)'(NUM);
            end
            if (i_valid[sum[GW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = sum[GW-1:0];
            end
        end
    end

    assign w_eop = i_valid[r_grant] & i_ready & i_last[r_grant];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_prio_last <= GW'(NUM - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_prio_last <= w_prio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio_last;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_winner;
                end
            end
            S_BUSY: begin
                if (w_eop) begin
                    w_state_nxt = S_IDLE;
                    w_prio_nxt  = r_grant;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_ready = '0;
        if (r_state == S_BUSY) begin
            o_valid          = i_valid[r_grant];
            o_data           = w_src_data[r_grant];
            o_last           = i_last[r_grant];
            o_ready[r_grant] = i_ready;
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state == S_BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus a random phase, checked
// cycle by cycle against a packet-level round-robin model and a beat scoreboard.
module tb_axis_rr_arbiter;
    localparam int NUM = 4;
    localparam int DW  = 32;
    localparam int GW  = $clog2(NUM);

    logic              clk = 1'b0;
    logic              i_reset;
    logic [NUM-1:0]    i_valid;
    logic [NUM*DW-1:0] i_data;
    logic [NUM-1:0]    i_last;
    logic [NUM-1:0]    o_ready;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic              i_ready;
    logic [GW-1:0]     o_grant;
    logic              o_busy;

    axis_rr_arbiter #(.NUM(NUM), .DW(DW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .o_ready(o_ready),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Source side: per-source packet queues of {last, data}
    logic [DW:0]    src_q [NUM][$];
    bit             src_v [NUM];
    int             stall [NUM];
    int             delivered [NUM];
    logic [DW-1:0]  drv_data [NUM];
    bit             drv_last [NUM];
    int             p_valid;
    int             p_ready;
    bit             toggle_ready;

    // Reference model: packet-level round robin
    bit             m_busy;
    int             m_grant;
    int             m_last_served;
    bit             m_first;
    logic [DW:0]    exp_q [$];
    int             glog [$];

    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int pick_winner(int last_served);
        for (int i = 1; i <= NUM; i++) begin
            if (src_v[(last_served + i) % NUM]) return (last_served + i) % NUM;
        end
        return -1;
    endfunction

    task automatic clear_bench();
        for (int k = 0; k < NUM; k++) begin
            src_q[k].delete();
            src_v[k] = 0;
            stall[k] = 0;
            delivered[k] = 0;
        end
        exp_q.delete();
        glog.delete();
        m_busy = 0;
        m_grant = 0;
        m_last_served = NUM - 1;
        m_first = 0;
        i_valid = '0;
        i_last = '0;
        i_data = '0;
    endtask

    task automatic add_pkt(input int k, input int len);
        for (int b = 0; b < len; b++) begin
            src_q[k].push_back({(b == len - 1), DW'($urandom)});
        end
    endtask

    task automatic step();
        int w;
        logic [DW:0] e;
        @(negedge clk);
        for (int k = 0; k < NUM; k++) begin
            if (!src_v[k] && src_q[k].size() > 0) begin
                if (stall[k] > 0) stall[k]--;
                else if ($urandom_range(0, 99) < p_valid) src_v[k] = 1;
            end
            if (src_v[k]) {drv_last[k], drv_data[k]} = src_q[k][0];
            else begin drv_last[k] = 0; drv_data[k] = $urandom; end
            i_valid[k] = src_v[k];
            i_last[k] = drv_last[k];
            i_data[k*DW +: DW] = drv_data[k];
        end
        i_ready = toggle_ready ? ~i_ready : ($urandom_range(0, 99) < p_ready);
        #1;
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("grant", 64'(o_grant), 64'(m_grant));
        chk("valid", 64'(o_valid), m_busy ? 64'(src_v[m_grant]) : 64'd0);
        chk("ready", 64'(o_ready), (m_busy && i_ready) ? (64'd1 << m_grant) : 64'd0);
        if (m_busy) begin
            chk("data", 64'(o_data), 64'(drv_data[m_grant]));
            chk("last", 64'(o_last), 64'(drv_last[m_grant]));
        end
        if (m_busy && src_v[m_grant] && i_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("scoreboard", {31'd0, o_last, o_data}, 64'(e));
            if (m_first) glog.push_back(int'(o_grant));
            m_first = 0;
            delivered[m_grant]++;
            void'(src_q[m_grant].pop_front());
            src_v[m_grant] = 0;
            if (drv_last[m_grant]) begin
                m_busy = 0;
                m_last_served = m_grant;
            end
        end else if (!m_busy) begin
            w = pick_winner(m_last_served);
            if (w >= 0) begin
                m_busy = 1;
                m_grant = w;
                m_first = 1;
                foreach (src_q[w][i]) begin
                    exp_q.push_back(src_q[w][i]);
                    if (src_q[w][i][DW]) break;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        bit pending = 1;
        while (pending && n < budget) begin
            step();
            n++;
            pending = m_busy;
            for (int k = 0; k < NUM; k++) if (src_q[k].size() > 0) pending = 1;
        end
        chk("drain_timeout", 64'(pending), 64'd0);
    endtask

    task automatic run_until_beats(input int k, input int beats, input int budget);
        int n = 0;
        while (delivered[k] < beats && n < budget) begin
            step();
            n++;
        end
        chk("beat_timeout", 64'(delivered[k] >= beats), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_reset = 1;
        i_ready = 0;
        clear_bench();
        repeat (2) @(negedge clk);
        i_reset = 0;
        #1;
    endtask

    initial begin
        i_reset = 1;
        i_ready = 0;
        toggle_ready = 0;
        p_valid = 100;
        p_ready = 100;
        clear_bench();

        // Reset state
        apply_reset();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);

        // Single source: 3-beat packet from source 2
        add_pkt(2, 3);
        run_until_idle(50);
        chk("single_npkt", 64'(glog.size()), 64'd1);
        chk("single_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);

        // Rotation: all sources with 2-beat packets
        apply_reset();
        for (int k = 0; k < NUM; k++) begin
            add_pkt(k, 2);
            add_pkt(k, 2);
        end
        run_until_idle(200);
        for (int i = 0; i < 2 * NUM; i++) begin
            chk($sformatf("rr_order%0d", i), 64'(glog.size() > i ? glog[i] : -1), 64'(i % NUM));
        end

        // Priority after grant: last served 1, then 0 and 3 together
        apply_reset();
        add_pkt(1, 2);
        run_until_idle(50);
        add_pkt(0, 2);
        add_pkt(3, 2);
        run_until_idle(50);
        chk("prio_first", 64'(glog.size() > 1 ? glog[1] : -1), 64'd3);
        chk("prio_second", 64'(glog.size() > 2 ? glog[2] : -1), 64'd0);

        // Backpressure: i_ready toggles during a 4-beat packet
        apply_reset();
        add_pkt(0, 4);
        toggle_ready = 1;
        run_until_idle(50);
        toggle_ready = 0;
        chk("bp_beats", 64'(delivered[0]), 64'd4);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Source stall: source 1 drops valid 3 cycles while source 2 waits
        apply_reset();
        add_pkt(1, 4);
        add_pkt(2, 2);
        run_until_beats(1, 2, 50);
        stall[1] = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_busy", 64'(o_busy), 64'd1);
            chk("stall_grant", 64'(o_grant), 64'd1);
        end
        run_until_idle(50);
        chk("stall_order0", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);
        chk("stall_order1", 64'(glog.size() > 1 ? glog[1] : -1), 64'd2);

        // Reset mid-packet during beat 2 of 5
        apply_reset();
        add_pkt(0, 5);
        run_until_beats(0, 1, 50);
        @(negedge clk);
        i_valid[0] = 1'b1;
        i_data[0 +: DW] = src_q[0][0][DW-1:0];
        i_ready = 0;
        i_reset = 1;
        @(negedge clk);
        i_reset = 0;
        clear_bench();
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd0);
        chk("mid_rst_grant", 64'(o_grant), 64'd0);
        add_pkt(0, 2);
        add_pkt(2, 2);
        run_until_idle(50);
        chk("mid_rst_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

        // Random traffic
        apply_reset();
        p_valid = 70;
        p_ready = 60;
        for (int i = 0; i < 40; i++) add_pkt($urandom_range(0, NUM - 1), $urandom_range(1, 4));
        run_until_idle(5000);
        chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
